// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with parallel load and a time-multiplexed digit scanner
// feeding a single BCD-to-decimal decoder. Optional macro: LEADING_ZERO_BLANK_EN.
module bcd_scan_counter #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_up,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_load_val,
  output logic [4*NUM_DIGITS-1:0] o_bcd,
  output logic                    o_tc,
  output logic                    o_ovf,
  output logic                    o_load_err,
  output logic                    o_a,
  output logic                    o_b,
  output logic                    o_c,
  output logic                    o_d,
  output logic                    o_cs,
  output logic [NUM_DIGITS-1:0]   o_digit_sel
);

  localparam int unsigned W    = 4 * NUM_DIGITS;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic StBlank = 1'b0;
  localparam logic StDrive = 1'b1;

  logic [W-1:0]    bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic            load_err_q, load_err_d;
  logic            state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [3:0]      nib_q, nib_d;

  logic       carry;
  logic       all9;
  logic       all0;
  logic [3:0] dig;
  logic [3:0] cur_dig;

  // Counter next state; carry/borrow out of the top digit is the wrap indication.
  always_comb begin
    bcd_d      = bcd_q;
    ovf_d      = 1'b0;
    load_err_d = 1'b0;
    carry      = 1'b1;
    all9       = 1'b1;
    all0       = 1'b1;
    dig        = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      all9 = all9 & (bcd_q[4*k +: 4] == 4'd9);
      all0 = all0 & (bcd_q[4*k +: 4] == 4'd0);
    end
    if (i_load) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        dig = i_load_val[4*k +: 4];
        if (dig > 4'd9) begin
          bcd_d[4*k +: 4] = 4'd0;
          load_err_d      = 1'b1;
        end else begin
          bcd_d[4*k +: 4] = dig;
        end
      end
    end else if (i_en) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        dig = bcd_q[4*k +: 4];
        if (carry) begin
          if (i_up) begin
            if (dig == 4'd9) begin
              bcd_d[4*k +: 4] = 4'd0;
            end else begin
              bcd_d[4*k +: 4] = dig + 4'd1;
              carry           = 1'b0;
            end
          end else begin
            if (dig == 4'd0) begin
              bcd_d[4*k +: 4] = 4'd9;
            end else begin
              bcd_d[4*k +: 4] = dig - 4'd1;
              carry           = 1'b0;
            end
          end
        end
      end
      ovf_d = carry;
    end
  end

  always_comb begin
    cur_dig = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IdxW'(k)) cur_dig = bcd_q[4*k +: 4];
    end
  end

  always_comb begin
    o_digit_sel = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IdxW'(k)) o_digit_sel[k] = 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lz_q, lz_d;
  logic hi_zero;

  // Digit is suppressed when it and every more-significant digit are zero (digit 0 never).
  always_comb begin
    hi_zero = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IdxW'(k) >= idx_q) hi_zero = hi_zero & (bcd_q[4*k +: 4] == 4'd0);
    end
    lz_d = (state_q == StBlank) ? ((idx_q != '0) && hi_zero) : lz_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) lz_q <= 1'b0;
    else       lz_q <= lz_d;
  end

  assign o_cs = (state_q == StDrive) && !lz_q;
`else
  assign o_cs = (state_q == StDrive);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    nib_d   = nib_q;
    if (state_q == StBlank) begin
      state_d = StDrive;
      cnt_d   = '0;
      nib_d   = cur_dig;
    end else if (cnt_q == CntW'(SCAN_DIV - 1)) begin
      state_d = StBlank;
      idx_d   = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
      state_q    <= StBlank;
      cnt_q      <= '0;
      idx_q      <= '0;
      nib_q      <= 4'd0;
    end else begin
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      nib_q      <= nib_d;
    end
  end

  assign o_bcd      = bcd_q;
  assign o_tc       = i_up ? all9 : all0;
  assign o_ovf      = ovf_q;
  assign o_load_err = load_err_q;
  assign o_a        = nib_q[0];
  assign o_b        = nib_q[1];
  assign o_c        = nib_q[2];
  assign o_d        = nib_q[3];

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed self-checking bench for bcd_scan_counter (NUM_DIGITS=4, SCAN_DIV=4).
module tb_bcd_scan_counter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_en;
  logic        i_up;
  logic        i_load;
  logic [15:0] i_load_val;
  logic [15:0] o_bcd;
  logic        o_tc, o_ovf, o_load_err;
  logic        o_a, o_b, o_c, o_d, o_cs;
  logic [3:0]  o_digit_sel;

  int n_cmp = 0;
  int n_err = 0;

  bcd_scan_counter #(
    .NUM_DIGITS(4),
    .SCAN_DIV  (4)
  ) u_dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_up       (i_up),
    .i_load     (i_load),
    .i_load_val (i_load_val),
    .o_bcd      (o_bcd),
    .o_tc       (o_tc),
    .o_ovf      (o_ovf),
    .o_load_err (o_load_err),
    .o_a        (o_a),
    .o_b        (o_b),
    .o_c        (o_c),
    .o_d        (o_d),
    .o_cs       (o_cs),
    .o_digit_sel(o_digit_sel)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] val);
    i_load = 1'b1; i_en = 1'b0; i_load_val = val;
    tick();
    i_load = 1'b0;
  endtask

  logic [3:0] exp_nib [4];
  logic       exp_cs  [4];

  initial begin
    i_rst = 1'b1; i_en = 1'b0; i_up = 1'b1; i_load = 1'b0; i_load_val = 16'h0;
    tick();
    tick();
    check("rst_bcd", o_bcd, 16'h0000);
    check("rst_cs", o_cs, 1'b0);
    check("rst_sel", o_digit_sel, 4'b0001);
    check("rst_ovf", o_ovf, 1'b0);
    check("rst_lerr", o_load_err, 1'b0);
    i_rst = 1'b0;
    tick();
    check("rel_cs", o_cs, 1'b1);
    check("rel_nib", {o_d, o_c, o_b, o_a}, 4'h0);
    check("rel_sel", o_digit_sel, 4'b0001);

    // Up carry chain
    load(16'h0999);
    check("ld_0999", o_bcd, 16'h0999);
    check("ld_0999_err", o_load_err, 1'b0);
    i_en = 1'b1; i_up = 1'b1;
    tick();
    i_en = 1'b0;
    check("up_carry", o_bcd, 16'h1000);
    check("up_carry_ovf", o_ovf, 1'b0);

    // Up wrap
    i_up = 1'b1;
    load(16'h9999);
    check("tc_up", o_tc, 1'b1);
    i_up = 1'b0; #1;
    check("tc_up_dirdown", o_tc, 1'b0);
    i_up = 1'b1; i_en = 1'b1;
    tick();
    i_en = 1'b0;
    check("up_wrap", o_bcd, 16'h0000);
    check("up_wrap_ovf", o_ovf, 1'b1);
    tick();
    check("up_wrap_ovf_end", o_ovf, 1'b0);
    check("up_hold", o_bcd, 16'h0000);

    // Down wrap and borrow
    i_up = 1'b0;
    load(16'h0000);
    check("tc_down", o_tc, 1'b1);
    i_en = 1'b1;
    tick();
    i_en = 1'b0;
    check("dn_wrap", o_bcd, 16'h9999);
    check("dn_wrap_ovf", o_ovf, 1'b1);
    tick();
    check("dn_wrap_ovf_end", o_ovf, 1'b0);
    load(16'h1000);
    check("tc_down_nz", o_tc, 1'b0);
    i_en = 1'b1;
    tick();
    i_en = 1'b0;
    check("dn_borrow", o_bcd, 16'h0999);
    check("dn_borrow_ovf", o_ovf, 1'b0);

    // Invalid load
    load(16'h3A7F);
    check("bad_ld", o_bcd, 16'h3070);
    check("bad_ld_err", o_load_err, 1'b1);
    tick();
    check("bad_ld_err_end", o_load_err, 1'b0);

    // Load beats enable; load during an all-9s wrap suppresses ovf
    i_up = 1'b1;
    load(16'h9999);
    i_load = 1'b1; i_en = 1'b1; i_load_val = 16'h0005;
    tick();
    i_load = 1'b0; i_en = 1'b0;
    check("ld_pri", o_bcd, 16'h0005);
    check("ld_pri_ovf", o_ovf, 1'b0);

    // Scan sequence: realign with reset, load during first slot, wait one full period
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    i_load = 1'b1; i_load_val = 16'h0042;
    tick();
    i_load = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    exp_nib[0] = 4'h2; exp_nib[1] = 4'h4; exp_nib[2] = 4'h0; exp_nib[3] = 4'h0;
`ifdef LEADING_ZERO_BLANK_EN
    exp_cs[0] = 1'b1; exp_cs[1] = 1'b1; exp_cs[2] = 1'b0; exp_cs[3] = 1'b0;
`else
    exp_cs[0] = 1'b1; exp_cs[1] = 1'b1; exp_cs[2] = 1'b1; exp_cs[3] = 1'b1;
`endif
    for (int s = 0; s < 4; s++) begin
      check($sformatf("scan_blank_cs%0d", s), o_cs, 1'b0);
      check($sformatf("scan_blank_sel%0d", s), o_digit_sel, 4'b0001 << s);
      for (int j = 0; j < 4; j++) begin
        tick();
        check($sformatf("scan_cs%0d_%0d", s, j), o_cs, exp_cs[s]);
        check($sformatf("scan_sel%0d_%0d", s, j), o_digit_sel, 4'b0001 << s);
        check($sformatf("scan_nib%0d_%0d", s, j), {o_d, o_c, o_b, o_a}, exp_nib[s]);
      end
      tick();
    end

    // Mid-DRIVE count change keeps the snapshot until the next BLANK
    check("mid_blank", o_cs, 1'b0);
    tick();
    check("mid_nib0", {o_d, o_c, o_b, o_a}, 4'h2);
    i_load = 1'b1; i_load_val = 16'h0091;
    tick();
    i_load = 1'b0;
    check("mid_bcd", o_bcd, 16'h0091);
    check("mid_nib1", {o_d, o_c, o_b, o_a}, 4'h2);
    tick();
    check("mid_nib2", {o_d, o_c, o_b, o_a}, 4'h2);
    tick();
    check("mid_nib3", {o_d, o_c, o_b, o_a}, 4'h2);
    tick();
    check("mid_next_blank", o_cs, 1'b0);
    check("mid_next_sel", o_digit_sel, 4'b0010);
    tick();
    check("mid_new_nib", {o_d, o_c, o_b, o_a}, 4'h9);
    check("mid_new_cs", o_cs, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
